// File: rtl/ysyx_25040111_alu_pkg.sv
// ALU operation encoding shared by the pipelined adder and the ALU decoder.
// Helpers derive the operand-B inversion and the effective carry-in from an opcode.
package ysyx_25040111_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } alu_op_e;

  // SUB and SBB both add the one's complement of B.
  function automatic logic op_inv_b(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_cin(input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040111_cla_pipe_if.sv
// Valid/ready operation and result channels of the pipelined adder/subtractor.
// The producer/consumer side uses master; the adder uses slave.
interface ysyx_25040111_cla_pipe_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/ysyx_25040111_cla_blk.sv
// Combinational BLK-bit two-level carry-lookahead adder: 4-bit group P/G cells
// feeding a flattened lookahead across the BLK/4 groups.
module ysyx_25040111_cla_blk #(
  parameter int BLK = 16
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           cmsb,
  output logic           zero
);

  localparam int NG = BLK / 4;

  logic [BLK-1:0] p, g, c;
  logic [NG-1:0]  gp, gg;
  logic [NG:0]    cg;

  // Carry into position n of a 4-bit slice, as a single sum of products.
  function automatic logic carry4(input logic [3:0] gv, input logic [3:0] pv,
                                  input logic ci, input int n);
    logic r, t;
    r = 1'b0;
    t = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      if (k < n) begin
        r = r | (t & gv[k]);
        t = t & pv[k];
      end
    end
    return r | (t & ci);
  endfunction

  function automatic logic carry_grp(input logic [NG-1:0] gv, input logic [NG-1:0] pv,
                                     input logic ci, input int n);
    logic r, t;
    r = 1'b0;
    t = 1'b1;
    for (int k = NG - 1; k >= 0; k--) begin
      if (k < n) begin
        r = r | (t & gv[k]);
        t = t & pv[k];
      end
    end
    return r | (t & ci);
  endfunction

  assign p = a ^ b;
  assign g = a & b;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    assign gp[j] = &p[4*j +: 4];
    assign gg[j] = carry4(g[4*j +: 4], p[4*j +: 4], 1'b0, 4);
    for (genvar k = 0; k < 4; k++) begin : g_bit
      assign c[4*j+k] = carry4(g[4*j +: 4], p[4*j +: 4], cg[j], k);
    end
  end

  for (genvar j = 0; j <= NG; j++) begin : g_gc
    assign cg[j] = carry_grp(gg, gp, cin, j);
  end

  assign sum  = p ^ c;
  assign cout = cg[NG];
  assign cmsb = c[BLK-1];
  assign zero = ~|sum;

endmodule

// File: rtl/ysyx_25040111_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit block per stage, block
// carry registered between stages, global stall under valid/ready flow control.
module ysyx_25040111_cla_pipe
  import ysyx_25040111_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_25040111_cla_pipe_if.slave   bus
);

  localparam int NSTG = WIDTH / BLK;

  logic             en;
  logic             last_valid;
  logic [WIDTH-1:0] b_ent;
  logic             c_ent;
  logic             ovf_q;

  // x_q holds the sum bits resolved so far below the stage boundary and the
  // untouched A bits above it, so one register carries both.
  logic [WIDTH-1:0] x_q [NSTG];
  logic             c_q [NSTG];
  logic             z_q [NSTG];
  logic             v_q [NSTG];

  assign b_ent       = op_inv_b(bus.in_op) ? ~bus.in_b : bus.in_b;
  assign c_ent       = op_cin(bus.in_op, bus.in_cin);
  assign en          = !last_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    localparam int LO = i * BLK;
    localparam int WB = WIDTH - LO;

    logic [WIDTH-1:0] x_in, x_d;
    logic [WB-1:0]    b_src;
    logic             c_in, z_in, v_in;
    logic [BLK-1:0]   s;
    logic             co, cm, z;

    if (i == 0) begin : g_head
      assign x_in  = bus.in_a;
      assign b_src = b_ent;
      assign c_in  = c_ent;
      assign z_in  = 1'b1;
      assign v_in  = bus.in_valid;
    end else begin : g_link
      assign x_in  = x_q[i-1];
      assign b_src = g_stg[i-1].g_fwd.b_q;
      assign c_in  = c_q[i-1];
      assign z_in  = z_q[i-1];
      assign v_in  = v_q[i-1];
    end

    ysyx_25040111_cla_blk #(.BLK(BLK)) u_blk (
      .a    (x_in[LO +: BLK]),
      .b    (b_src[BLK-1:0]),
      .cin  (c_in),
      .sum  (s),
      .cout (co),
      .cmsb (cm),
      .zero (z)
    );

    always_comb begin
      // NOTE: assigning the whole vector before the slice overwrite means every
      // bit has a value on every evaluation, so no latch is inferred.
      x_d = x_in;
      x_d[LO +: BLK] = s;
    end

    // NOTE: datapath registers carry no reset; only the valid bits need a known
    // value, and every out_* is gated by out_valid.
    always_ff @(posedge clk) begin
      if (en) begin
        x_q[i] <= x_d;
        c_q[i] <= co;
        z_q[i] <= z_in & z;
      end
    end

    // NOTE: non-blocking updates let each stage capture its predecessor's
    // pre-edge value, which is what makes this a pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  v_q[i] <= 1'b0;
      else if (en) v_q[i] <= v_in;
    end

    // B bits still to be consumed travel right-aligned, shrinking per stage.
    if (i < NSTG - 1) begin : g_fwd
      logic [WB-BLK-1:0] b_q;
      always_ff @(posedge clk) begin
        if (en) b_q <= b_src[WB-1:BLK];
      end
    end

    if (i == NSTG - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (en) ovf_q <= cm ^ co;
      end
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = cm;
    end
  end

  assign last_valid    = v_q[NSTG-1];
  assign bus.out_valid = last_valid;
  assign bus.out_sum   = last_valid ? x_q[NSTG-1] : '0;
  assign bus.out_cout  = last_valid & c_q[NSTG-1];
  assign bus.out_ovf   = last_valid & ovf_q;
  assign bus.out_zero  = last_valid & z_q[NSTG-1];

endmodule

// File: doc/ysyx_25040111_cla_pipe.md
# ysyx_25040111_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the NPC ALU datapath. Splits a WIDTH-bit operation into WIDTH/BLK blocks, each resolved by a two-level lookahead in its own pipeline stage, with the block carry registered between stages. It accepts one operation per cycle under valid/ready flow control and produces the sum plus carry, overflow and zero flags.

## Interface
- WIDTH, 32, operand width; multiple of BLK.
- BLK, 16, bits resolved per stage; multiple of 4, 4 ≤ BLK ≤ WIDTH.
- NSTG (localparam) = WIDTH/BLK, number of pipeline stages.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted on an edge where in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  00 ADD (a+b), 01 SUB (a+~b+1), 10 ADC (a+b+in_cin), 11 SBB (a+~b+in_cin).
- in_cin  in  1  carry-in, used by ADC/SBB only.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result on an edge where out_valid && out_ready.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of bit WIDTH-1 (SUB/SBB: 1 = no borrow).
- out_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_zero  out  1  out_sum == 0.

## Operation
- Operand B is inverted at entry for SUB/SBB; effective carry-in c0 = 0 (ADD), 1 (SUB), in_cin (ADC/SBB).
- Stage i (0..NSTG-1) combinationally computes bits [i*BLK +: BLK] from its stage-input operand slice and incoming carry, then registers: the low sum bits produced so far, the remaining upper operand slices, the block carry-out, a running zero bit (AND of per-block zero), and a valid bit.
- The last stage also registers the carry into bit WIDTH-1 to form out_ovf.
- Global stall: enable = !out_valid || out_ready. All stage registers, including valid bits, load only when enable is 1; in_ready = enable.
- Bubbles propagate as invalid entries; the data registers of invalid entries are don't-care, but out_* reads 0 when out_valid is 0.
- No internal state other than the pipeline registers; no FSM beyond per-stage valid bits.

## Timing
- Reset (asynchronous on rst_n low): all valid bits 0, out_valid 0, out_sum/out_cout/out_ovf/out_zero 0. in_ready is 1 during and after reset. Reset mid-operation discards all in-flight entries with no partial output.
- Latency NSTG cycles without stall: accepted in cycle c, out_valid in cycle c+NSTG. Default parameters: 2 cycles.
- Throughput: one operation per cycle while out_ready = 1.
- While out_valid && !out_ready, every pipeline register and all out_* signals hold stable and in_ready = 0. in_a/in_b/in_op/in_cin are don't-care when not accepted.
- Simultaneous output take and input accept in one edge is legal and required for full throughput.
- Wrap-around: the sum is modulo 2^WIDTH; carry beyond MSB appears only on out_cout.
- NSTG = 1 degenerates to a single registered full-width lookahead adder.
- Critical path per stage: one BLK-bit two-level lookahead plus the sum XOR.

## Structure
- Shared package ysyx_25040111_alu_pkg: op encoding constants (OP_ADD, OP_SUB, OP_ADC, OP_SBB) for reuse by the ALU decoder.
- One sub-module, ysyx_25040111_cla_blk (parameter BLK): combinational. Takes a, b and cin and outputs sum, cout, carry into its MSB, and zero. It uses 4-bit group propagate/generate cells and a second-level lookahead across the BLK/4 groups. The pipe generates NSTG instances.

## Test plan
- Default params, ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> 2 cycles later out_sum=0, cout=1, ovf=0, zero=1.
- SUB 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0; SUB 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- ADC 0x0000FFFF + 0x00000000 with cin=1 -> sum=0x00010000, which exercises the carry crossing the stage boundary; SBB 0x10 + ~0x10 with cin=0 -> sum=0xFFFFFFFF, cout=0.
- Back-to-back stream of 8 random ops with out_ready=1 -> 8 results in consecutive cycles, in order, matching a reference model.
- Hold out_ready=0 for 3 cycles with the pipe full -> in_ready=0, outputs stable; release -> no loss or duplication.
- Assert rst_n low with 2 ops in flight -> out_valid=0 immediately, no stale result after release. Repeat the random run with WIDTH=64/BLK=16 and WIDTH=8/BLK=8.
